// File: rtl/stream_min_max.sv
// Streaming frame min/max tracker with positions and element count.
// Valid/ready on both sides; result held until the consumer takes it.
module stream_min_max #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_signed,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_min,
    output logic [WIDTH-1:0] o_max,
    output logic [IDX_W-1:0] o_min_idx,
    output logic [IDX_W-1:0] o_max_idx,
    output logic [IDX_W:0]   o_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_run;
    logic             r_mode;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [IDX_W-1:0] r_min_idx;
    logic [IDX_W-1:0] r_max_idx;
    logic [IDX_W:0]   r_count;

    logic             w_accept;
    logic             w_lt_min;
    logic             w_gt_max;
    logic             w_full;
    logic [IDX_W:0]   w_cnt_nxt;

    // a < b via a + ~b + 1: sign-aware for signed, borrow-out for unsigned
    function automatic logic f_lt(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sgn
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        if (sgn)
            return (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];
        else
            return ~sum[WIDTH];
    endfunction

    assign o_ready   = r_run && (r_state != DONE);
    assign o_valid   = (r_state == DONE);
    assign w_accept  = i_valid && o_ready;
    assign w_cnt_nxt = r_count + 1'b1;
    assign w_full    = (w_cnt_nxt == DEPTH_C);
    assign w_lt_min  = f_lt(i_data, r_min, r_mode);
    assign w_gt_max  = f_lt(r_max, i_data, r_mode);

    assign o_min     = r_min;
    assign o_max     = r_max;
    assign o_min_idx = r_min_idx;
    assign o_max_idx = r_max_idx;
    assign o_count   = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_nxt = i_last ? DONE : ACC;
            end
            ACC: begin
                if (w_accept && (i_last || w_full))
                    w_state_nxt = DONE;
            end
            DONE: begin
                if (i_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode    <= 1'b0;
            r_min     <= '0;
            r_max     <= '0;
            r_min_idx <= '0;
            r_max_idx <= '0;
            r_count   <= '0;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_mode    <= i_signed;
                r_min     <= i_data;
                r_max     <= i_data;
                r_min_idx <= '0;
                r_max_idx <= '0;
                r_count   <= {{IDX_W{1'b0}}, 1'b1};
            end else begin
                // current count is the zero-based position of this element
                if (w_lt_min) begin
                    r_min     <= i_data;
                    r_min_idx <= r_count[IDX_W-1:0];
                end
                if (w_gt_max) begin
                    r_max     <= i_data;
                    r_max_idx <= r_count[IDX_W-1:0];
                end
                r_count <= w_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_stream_min_max.sv
// Directed bench for stream_min_max (WIDTH=8, DEPTH=4): frame table
// plus hand sequences for bubbles, backpressure and reset.
module tb_stream_min_max;

    logic       clk;
    logic       rst_n;
    logic       i_signed;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_data;
    logic       i_last;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_min;
    logic [7:0] o_max;
    logic [1:0] o_min_idx;
    logic [1:0] o_max_idx;
    logic [2:0] o_count;

    int n_pass  = 0;
    int n_total = 0;

    stream_min_max #(
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_signed (i_signed),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_last   (i_last),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_min    (o_min),
        .o_max    (o_max),
        .o_min_idx(o_min_idx),
        .o_max_idx(o_max_idx),
        .o_count  (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        int          n;
        logic        use_last;
        logic [31:0] d;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [1:0]  mi;
        logic [1:0]  xi;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // called at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [7:0] d, input logic l, input logic s);
        int n;
        n = 0;
        i_valid  = 1'b1;
        i_data   = d;
        i_last   = l;
        i_signed = s;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready)
            check("send_timeout", {31'b0, o_ready}, 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic release_result();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("released", {31'b0, o_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] dv;
        logic [7:0]  hmin, hmax;
        logic [2:0]  hcnt;

        rst_n    = 1'b0;
        i_signed = 1'b0;
        i_valid  = 1'b0;
        i_data   = 8'h00;
        i_last   = 1'b0;
        i_ready  = 1'b0;

        tbl[0] = '{1'b1, 4, 1'b1, 32'h05FB7F80, 8'h80, 8'h7F, 2'd3, 2'd2, 3'd4};
        tbl[1] = '{1'b0, 4, 1'b1, 32'h05FB7F80, 8'h05, 8'hFB, 2'd0, 2'd1, 3'd4};
        tbl[2] = '{1'b1, 1, 1'b1, 32'h9C000000, 8'h9C, 8'h9C, 2'd0, 2'd0, 3'd1};
        tbl[3] = '{1'b0, 2, 1'b1, 32'h00FF0000, 8'h00, 8'hFF, 2'd0, 2'd1, 3'd2};
        tbl[4] = '{1'b1, 3, 1'b1, 32'h80807F00, 8'h80, 8'h7F, 2'd0, 2'd2, 3'd3};
        tbl[5] = '{1'b1, 3, 1'b1, 32'hFF000100, 8'hFF, 8'h01, 2'd0, 2'd2, 3'd3};
        tbl[6] = '{1'b0, 4, 1'b0, 32'hFF0101FE, 8'h01, 8'hFF, 2'd1, 2'd0, 3'd4};

        // reset state
        #2;
        check("rst_ready", {31'b0, o_ready}, 32'd0);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_min",   {24'b0, o_min},   32'd0);
        check("rst_max",   {24'b0, o_max},   32'd0);
        check("rst_count", {29'b0, o_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready_pre", {31'b0, o_ready}, 32'd0);
        @(negedge clk);
        check("rel_ready", {31'b0, o_ready}, 32'd1);

        // frame table; i_signed flipped after the first element
        for (int k = 0; k < 7; k++) begin
            dv = tbl[k].d;
            for (int i = 0; i < tbl[k].n; i++)
                send(dv[31-8*i -: 8],
                     tbl[k].use_last && (i == tbl[k].n - 1),
                     (i == 0) ? tbl[k].sgn : ~tbl[k].sgn);
            check($sformatf("v%0d_valid", k), {31'b0, o_valid}, 32'd1);
            check($sformatf("v%0d_ready", k), {31'b0, o_ready}, 32'd0);
            check($sformatf("v%0d_min", k), {24'b0, o_min}, {24'b0, tbl[k].mn});
            check($sformatf("v%0d_max", k), {24'b0, o_max}, {24'b0, tbl[k].mx});
            check($sformatf("v%0d_mi", k), {30'b0, o_min_idx}, {30'b0, tbl[k].mi});
            check($sformatf("v%0d_xi", k), {30'b0, o_max_idx}, {30'b0, tbl[k].xi});
            check($sformatf("v%0d_cnt", k), {29'b0, o_count}, {29'b0, tbl[k].cnt});
            release_result();
        end

        // bubbles between elements, tie keeps earliest
        send(8'h10, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("bub_valid_mid", {31'b0, o_valid}, 32'd0);
        send(8'h10, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        send(8'h03, 1'b1, 1'b0);
        check("bub_valid", {31'b0, o_valid}, 32'd1);
        check("bub_min", {24'b0, o_min}, 32'h03);
        check("bub_mi", {30'b0, o_min_idx}, 32'd2);
        check("bub_max", {24'b0, o_max}, 32'h10);
        check("bub_xi", {30'b0, o_max_idx}, 32'd0);
        check("bub_cnt", {29'b0, o_count}, 32'd3);
        release_result();

        // full frame without i_last; 5th element held under backpressure
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        send(8'h04, 1'b0, 1'b0);
        i_valid  = 1'b1;
        i_data   = 8'h55;
        i_last   = 1'b1;
        i_signed = 1'b0;
        hmin = o_min;
        hmax = o_max;
        hcnt = o_count;
        check("full_cnt", {29'b0, o_count}, 32'd4);
        check("full_max", {24'b0, o_max}, 32'h04);
        for (int c = 0; c < 10; c++) begin
            check("hold_valid", {31'b0, o_valid}, 32'd1);
            check("hold_ready", {31'b0, o_ready}, 32'd0);
            check("hold_min", {24'b0, o_min}, {24'b0, hmin});
            check("hold_max", {24'b0, o_max}, {24'b0, hmax});
            check("hold_cnt", {29'b0, o_count}, {29'b0, hcnt});
            @(negedge clk);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("rel5_valid", {31'b0, o_valid}, 32'd0);
        check("rel5_ready", {31'b0, o_ready}, 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        check("e5_valid", {31'b0, o_valid}, 32'd1);
        check("e5_min", {24'b0, o_min}, 32'h55);
        check("e5_cnt", {29'b0, o_count}, 32'd1);
        release_result();

        // reset mid-frame discards partial results
        send(8'h00, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_min", {24'b0, o_min}, 32'd0);
        check("mrst_max", {24'b0, o_max}, 32'd0);
        check("mrst_cnt", {29'b0, o_count}, 32'd0);
        check("mrst_ready", {31'b0, o_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mrst_novalid", {31'b0, o_valid}, 32'd0);
        end
        send(8'h20, 1'b0, 1'b0);
        send(8'h30, 1'b1, 1'b0);
        check("after_valid", {31'b0, o_valid}, 32'd1);
        check("after_min", {24'b0, o_min}, 32'h20);
        check("after_max", {24'b0, o_max}, 32'h30);
        check("after_xi", {30'b0, o_max_idx}, 32'd1);
        check("after_cnt", {29'b0, o_count}, 32'd2);
        release_result();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
